// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU and its
// iterative multiply/divide datapath.
package alu_pkg;

    localparam int ALU_OPW = 4;

    typedef enum logic [ALU_OPW-1:0] {
        OP_AND  = 4'd0,
        OP_SGT  = 4'd1,
        OP_OR   = 4'd2,
        OP_NOT  = 4'd3,
        OP_ADD  = 4'd4,
        OP_SUB  = 4'd5,
        OP_PASS = 4'd6,
        OP_BEQ  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_SLL  = 4'd10,
        OP_MUL  = 4'd11,
        OP_DIVU = 4'd12
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } alu_state_e;

    // MUL and DIVU are the only opcodes that go through the iterative datapath.
    function automatic logic is_multi(input logic [ALU_OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative W-step datapath: unsigned shift-add multiply and restoring divide.
// go loads the operands; fin marks the cycle whose next-state values are final.
module alu_iter
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         fin,
    output logic [W-1:0] res,
    output logic [W-1:0] car
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_mq;
    logic [W-1:0]  r_md;
    logic [CW-1:0] r_cnt;
    logic          r_div;

    logic [W:0]    w_sum;
    logic [W-1:0]  w_mul_acc;
    logic [W-1:0]  w_mul_mq;
    logic [W:0]    w_sh;
    logic          w_borrow;
    logic [W-1:0]  w_div_acc;
    logic [W-1:0]  w_div_mq;
    logic [W-1:0]  w_acc_nx;
    logic [W-1:0]  w_mq_nx;

    // Multiply: {acc, mq} shifts right, adding the multiplicand when mq[0] is set.
    assign w_sum     = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_md} : {(W+1){1'b0}});
    assign w_mul_acc = w_sum[W:1];
    assign w_mul_mq  = {w_sum[0], r_mq[W-1:1]};

    // Divide: shift the next dividend bit into the remainder and subtract if it fits.
    // A zero divisor never borrows, leaving quotient all-ones and remainder = a.
    assign w_sh      = {r_acc, r_mq[W-1]};
    assign w_borrow  = (w_sh < {1'b0, r_md});
    assign w_div_acc = w_borrow ? w_sh[W-1:0] : W'(w_sh - {1'b0, r_md});
    assign w_div_mq  = {r_mq[W-2:0], ~w_borrow};

    assign w_acc_nx  = r_div ? w_div_acc : w_mul_acc;
    assign w_mq_nx   = r_div ? w_div_mq  : w_mul_mq;

    assign fin = (r_cnt == CW'(1));
    assign res = w_mq_nx;
    assign car = w_acc_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_mq  <= '0;
            r_md  <= '0;
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (go) begin
            r_acc <= '0;
            r_mq  <= a;
            r_md  <= b;
            r_cnt <= CW'(W);
            r_div <= is_div;
        end else if (r_cnt != '0) begin
            r_acc <= w_acc_nx;
            r_mq  <= w_mq_nx;
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops register one cycle after start, MUL/DIVU
// iterate W cycles. Handshake: start is taken only in IDLE with done low; done
// pulses one cycle when outputs change, and outputs hold until the next done.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   ra_in,
    input  logic [W-1:0]   rb_in,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   res_out,
    output logic [W-1:0]   car_out,
    output logic           zero,
    output logic           jump,
    output logic           dz,
    output logic           dbg_state
);

    alu_state_e r_state;
    alu_state_e w_state_nx;
    logic       r_done;
    logic [W-1:0] r_res;
    logic [W-1:0] r_car;
    logic       r_zero;
    logic       r_jump;
    logic       r_dz;
    logic       r_dz_pend;

    logic [ALU_OPW-1:0] w_op;
    logic         w_accept;
    logic         w_multi;
    logic         w_go;
    logic         w_fin;
    logic [W-1:0] w_it_res;
    logic [W-1:0] w_it_car;
    logic [W-1:0] w_res;
    logic [W-1:0] w_car;
    logic         w_jump;
    logic [W:0]   w_add;
    logic [W:0]   w_sub;
    logic [2*W-1:0] w_shr;
    logic [2*W-1:0] w_sra;
    logic [2*W-1:0] w_shl;

    assign w_op     = ALU_OPW'(op);
    assign w_multi  = is_multi(w_op);
    assign w_accept = start && !r_done && (r_state == ST_IDLE);

    assign w_add = {1'b0, ra_in} + {1'b0, rb_in};
    assign w_sub = {1'b0, ra_in} - {1'b0, rb_in};
    // Shift amounts of 2W or more push every bit out of the double-width window.
    assign w_shr = {ra_in, {W{1'b0}}} >> rb_in;
    assign w_sra = $signed({ra_in, {W{1'b0}}}) >>> rb_in;
    assign w_shl = {{W{1'b0}}, ra_in} << rb_in;

    always_comb begin
        w_res  = '0;
        w_car  = '0;
        w_jump = 1'b0;
        case (w_op)
            OP_AND:  w_res = ra_in & rb_in;
            OP_SGT:  w_res = ($signed(ra_in) > $signed(rb_in)) ? {W{1'b1}} : '0;
            OP_OR:   w_res = ra_in | rb_in;
            OP_NOT:  w_res = ~ra_in;
            OP_ADD:  begin w_res = w_add[W-1:0]; w_car = {{(W-1){1'b0}}, w_add[W]}; end
            OP_SUB:  begin w_res = w_sub[W-1:0]; w_car = {{(W-1){1'b0}}, w_sub[W]}; end
            OP_PASS: w_res = ra_in;
            OP_BEQ:  w_jump = (ra_in == rb_in);
            OP_SRL:  begin w_res = w_shr[2*W-1:W]; w_car = w_shr[W-1:0]; end
            OP_SRA:  begin w_res = w_sra[2*W-1:W]; w_car = w_sra[W-1:0]; end
            OP_SLL:  begin w_res = w_shl[W-1:0];   w_car = w_shl[2*W-1:W]; end
            default: ;
        endcase
    end

    alu_iter #(.W(W)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .go     (w_go),
        .is_div (w_op == OP_DIVU),
        .a      (ra_in),
        .b      (rb_in),
        .fin    (w_fin),
        .res    (w_it_res),
        .car    (w_it_car)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_go       = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept && w_multi) begin
                w_state_nx = ST_ITER;
                w_go       = 1'b1;
            end
            ST_ITER: if (w_fin) w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done    <= 1'b0;
            r_res     <= '0;
            r_car     <= '0;
            r_zero    <= 1'b1;
            r_jump    <= 1'b0;
            r_dz      <= 1'b0;
            r_dz_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_go) r_dz_pend <= (w_op == OP_DIVU) && (rb_in == '0);
            if (w_accept && !w_multi) begin
                r_done <= 1'b1;
                r_res  <= w_res;
                r_car  <= w_car;
                r_zero <= (w_res == '0);
                r_jump <= w_jump;
                r_dz   <= 1'b0;
            end else if ((r_state == ST_ITER) && w_fin) begin
                r_done <= 1'b1;
                r_res  <= w_it_res;
                r_car  <= w_it_car;
                r_zero <= (w_it_res == '0);
                r_jump <= 1'b0;
                r_dz   <= r_dz_pend;
            end
        end
    end

    assign busy      = (r_state == ST_ITER);
    assign done      = r_done;
    assign res_out   = r_res;
    assign car_out   = r_car;
    assign zero      = r_zero;
    assign jump      = r_jump;
    assign dz        = r_dz;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (W=8): directed vector table, random ops against a
// behavioural model, and hand sequences for ignored starts and mid-op reset.
module tb_alu_seq;

    localparam int W        = 8;
    localparam int MAX_WAIT = 40;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] ra_in;
    logic [W-1:0] rb_in;
    logic         busy;
    logic         done;
    logic [W-1:0] res_out;
    logic [W-1:0] car_out;
    logic         zero;
    logic         jump;
    logic         dz;
    logic         dbg_state;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] car;
        logic         zero;
        logic         jump;
        logic         dz;
    } vec_t;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    vec_t         tbl[$];

    alu_seq #(.W(W), .OPW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .ra_in     (ra_in),
        .rb_in     (rb_in),
        .busy      (busy),
        .done      (done),
        .res_out   (res_out),
        .car_out   (car_out),
        .zero      (zero),
        .jump      (jump),
        .dz        (dz),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] r, input logic [W-1:0] c,
                                input logic z, input logic j, input logic d);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.res = r; v.car = c; v.zero = z; v.jump = j; v.dz = d;
        return v;
    endfunction

    // Behavioural reference computed from the operation definitions.
    function automatic vec_t ref_model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t          e;
        logic [2*W-1:0] t;
        longint        p;
        int            sa;
        int            sb;
        e = mk(o, a, b, '0, '0, 1'b0, 1'b0, 1'b0);
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        case (o)
            4'd0:  e.res = a & b;
            4'd1:  e.res = (sa > sb) ? {W{1'b1}} : '0;
            4'd2:  e.res = a | b;
            4'd3:  e.res = ~a;
            4'd4:  begin
                p = longint'(a) + longint'(b);
                e.res = p[W-1:0];
                e.car = p[2*W-1:W];
            end
            4'd5:  begin
                e.res = a - b;
                if (a < b) e.car = 1;
            end
            4'd6:  e.res = a;
            4'd7:  e.jump = (a == b);
            4'd8, 4'd9: begin
                t = (int'(b) >= 2*W) ? '0 : ({a, {W{1'b0}}} >> b);
                if (o == 4'd9 && a[W-1]) t = t | ~({(2*W){1'b1}} >> b);
                e.res = t[2*W-1:W];
                e.car = t[W-1:0];
            end
            4'd10: begin
                t = (int'(b) >= 2*W) ? '0 : ({{W{1'b0}}, a} << b);
                e.res = t[W-1:0];
                e.car = t[2*W-1:W];
            end
            4'd11: begin
                p = longint'(a) * longint'(b);
                e.res = p[W-1:0];
                e.car = p[2*W-1:W];
            end
            4'd12: begin
                if (b == '0) begin
                    e.res = '1; e.car = a; e.dz = 1'b1;
                end else begin
                    e.res = a / b; e.car = a % b;
                end
            end
            default: ;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic run_vec(input vec_t v);
        int           lat;
        int           bcnt;
        logic [W-1:0] q;
        string        tag;
        tag = $sformatf("op%0d_a%0h_b%0h", v.op, v.a, v.b);
        exp_q.push_back(v.res);
        start = 1'b1; op = v.op; ra_in = v.a; rb_in = v.b;
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); ra_in = W'($urandom); rb_in = W'($urandom);
        lat = 1; bcnt = 0;
        while (!done && lat < MAX_WAIT) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, W'(lat), W'((v.op == 4'd11 || v.op == 4'd12) ? W + 1 : 1));
        chk({tag, "_busy_cycles"}, W'(bcnt), W'((v.op == 4'd11 || v.op == 4'd12) ? W : 0));
        chk({tag, "_busy_in_done"}, W'(busy), '0);
        q = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({tag, "_res"},  res_out, q);
        chk({tag, "_car"},  car_out, v.car);
        chk({tag, "_zero"}, W'(zero), W'(v.zero));
        chk({tag, "_jump"}, W'(jump), W'(v.jump));
        chk({tag, "_dz"},   W'(dz),   W'(v.dz));
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, W'(done), '0);
        chk({tag, "_hold_res"}, res_out, q);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  W'(busy), '0);
        chk({tag, "_done"},  W'(done), '0);
        chk({tag, "_res"},   res_out, '0);
        chk({tag, "_car"},   car_out, '0);
        chk({tag, "_zero"},  W'(zero), W'(1));
        chk({tag, "_jump"},  W'(jump), '0);
        chk({tag, "_dz"},    W'(dz),   '0);
    endtask

    // ---------------- test ----------------
    initial begin
        int           lat;
        int           dcnt;
        logic [3:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;

        tbl.push_back(mk(4'd4,  8'hFF, 8'h01, 8'h00, 8'h01, 1, 0, 0));
        tbl.push_back(mk(4'd11, 8'hFF, 8'hFF, 8'h01, 8'hFE, 0, 0, 0));
        tbl.push_back(mk(4'd12, 8'd200, 8'd7, 8'd28, 8'd4, 0, 0, 0));
        tbl.push_back(mk(4'd12, 8'h5A, 8'h00, 8'hFF, 8'h5A, 0, 0, 1));
        tbl.push_back(mk(4'd9,  8'h90, 8'd3,  8'hF2, 8'h00, 0, 0, 0));
        tbl.push_back(mk(4'd10, 8'h81, 8'd1,  8'h02, 8'h01, 0, 0, 0));
        tbl.push_back(mk(4'd8,  8'hAB, 8'd20, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk(4'd7,  8'h33, 8'h33, 8'h00, 8'h00, 1, 1, 0));
        tbl.push_back(mk(4'd0,  8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0));
        tbl.push_back(mk(4'd1,  8'h80, 8'h01, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk(4'd1,  8'h05, 8'hFF, 8'hFF, 8'h00, 0, 0, 0));
        tbl.push_back(mk(4'd5,  8'h03, 8'h05, 8'hFE, 8'h01, 0, 0, 0));
        tbl.push_back(mk(4'd5,  8'h05, 8'h03, 8'h02, 8'h00, 0, 0, 0));
        tbl.push_back(mk(4'd3,  8'h0F, 8'h00, 8'hF0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(4'd2,  8'h0F, 8'hF0, 8'hFF, 8'h00, 0, 0, 0));
        tbl.push_back(mk(4'd6,  8'h42, 8'h99, 8'h42, 8'h00, 0, 0, 0));
        tbl.push_back(mk(4'd13, 8'h12, 8'h34, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk(4'd11, 8'h00, 8'h37, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk(4'd12, 8'hFF, 8'hFF, 8'h01, 8'h00, 0, 0, 0));
        tbl.push_back(mk(4'd12, 8'h07, 8'd200, 8'h00, 8'h07, 1, 0, 0));
        tbl.push_back(mk(4'd8,  8'hAB, 8'd4,  8'h0A, 8'hB0, 0, 0, 0));
        tbl.push_back(mk(4'd9,  8'h90, 8'd20, 8'hFF, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(4'd10, 8'h81, 8'd9,  8'h00, 8'h02, 1, 0, 0));
        tbl.push_back(mk(4'd7,  8'h33, 8'h34, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk(4'd4,  8'h7F, 8'h01, 8'h80, 8'h00, 0, 0, 0));

        // Reset with start held high: start must be ignored.
        reset = 1'b1; start = 1'b1; op = 4'd4; ra_in = 8'h01; rb_in = 8'h02;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("start_during_reset_done", W'(done), '0);

        foreach (tbl[i]) run_vec(tbl[i]);

        for (int i = 0; i < 200; i++) begin
            o = 4'($urandom_range(0, 15));
            a = W'($urandom);
            b = W'($urandom);
            if ((o >= 4'd8 && o <= 4'd10) && $urandom_range(0, 1) == 1) b = W'($urandom_range(0, 18));
            if (o == 4'd12 && $urandom_range(0, 3) == 0) b = '0;
            if (o == 4'd7 && $urandom_range(0, 1) == 1) b = a;
            run_vec(ref_model(o, a, b));
        end

        // MUL with start pulses at cycles 3 and 6 and operands changing mid-op.
        start = 1'b1; op = 4'd11; ra_in = 8'hC3; rb_in = 8'h5A;
        @(posedge clk); #1;
        start = 1'b0; lat = 1;
        while (!done && lat < MAX_WAIT) begin
            ra_in = W'($urandom); rb_in = W'($urandom);
            if (lat == 3 || lat == 6) begin
                start = 1'b1; op = 4'd4;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("mul_ign_latency", W'(lat), W'(W + 1));
        chk("mul_ign_res", res_out, 8'h8E);
        chk("mul_ign_car", car_out, 8'h44);
        // Start during the done cycle is dropped, not queued.
        start = 1'b1; op = 4'd4; ra_in = 8'h01; rb_in = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_done_cycle_done", W'(done), '0);
        chk("start_in_done_cycle_res", res_out, 8'h8E);
        dcnt = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("no_queued_done", W'(dcnt), '0);

        // Reset at cycle 4 of a DIVU aborts it.
        start = 1'b1; op = 4'd12; ra_in = 8'd200; rb_in = 8'd7;
        @(posedge clk); #1;
        start = 1'b0; lat = 1;
        while (lat < 4) begin
            @(posedge clk); #1;
            lat++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset_vals("div_abort");
        run_vec(mk(4'd4, 8'h12, 8'h34, 8'h46, 8'h00, 0, 0, 0));
        dcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("div_abort_no_done", W'(dcnt), '0);
        chk("div_abort_res_kept", res_out, 8'h46);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
